dw_kernel_loader: RTL

Sequencer that fetches one 3x3 depthwise kernel (9 INT8 taps) from weight_memory and presents it as a parallel kernel array to depthwise_conv3x3_engine. It sits directly upstream of the conv engine and is the only master of the weight_memory read port. Per channel, the controller supplies a base address and a start pulse. The loader issues 9 single-outstanding reads, captures each tap in order, and flags completion.

---
 rtl/dw_kernel_loader_if.sv | 25 ++
 rtl/dw_kernel_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dw_kernel_loader_if.sv
// Read-port bundle between dw_kernel_loader (master) and weight_memory (slave).
// One request per read_en strobe; read_valid/read_data return the word later.
interface dw_kernel_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;

    modport master (
        output read_addr,
        output read_en,
        input  read_data,
        input  read_valid
    );

    modport slave (
        input  read_addr,
        input  read_en,
        output read_data,
        output read_valid
    );
endinterface

// File: rtl/dw_kernel_loader.sv
// dw_kernel_loader: fetches one 3x3 depthwise kernel (KERNEL_TAPS taps) from
// weight_memory with a single outstanding read at a time and presents it as a
// parallel tap array for depthwise_conv3x3_engine.
//
// Optional feature macro: DW_KERNEL_AUTOSTART_EN
//   When defined, o_conv_clear and o_conv_start exist and the completion path
//   becomes CLR -> STRT -> DONE, so the engine is cleared and started before
//   done pulses. When undefined those ports are absent.
module dw_kernel_loader #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned KERNEL_TAPS    = 9,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_kernel_valid,
    output logic [DATA_WIDTH-1:0] o_kernel_out [KERNEL_TAPS-1:0],
`ifdef DW_KERNEL_AUTOSTART_EN
    output logic                  o_conv_clear,
    output logic                  o_conv_start,
`endif
    dw_kernel_loader_if.master    mem_bus
);

    localparam int unsigned IDX_W = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_TAPS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

`ifdef DW_KERNEL_AUTOSTART_EN
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StErr,
        StClr,
        StStrt
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StErr
    } state_e;
`endif

    state_e                r_state;
    state_e                w_state_d;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [IDX_W-1:0]      r_index;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_kernel_valid;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_kernel [KERNEL_TAPS-1:0];

    logic                  w_last_tap;
    logic                  w_timeout;

    assign w_last_tap = (r_index == LAST_IDX);
    assign w_timeout  = (r_timer == TMR_LAST);

    // Address wraps naturally modulo 2^ADDR_WIDTH.
    assign mem_bus.read_addr = r_base + ADDR_WIDTH'(r_index);

    assign o_error        = r_error;
    assign o_kernel_valid = r_kernel_valid;
    assign o_kernel_out   = r_kernel;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and state-decoded strobes.
    always_comb begin
        w_state_d       = r_state;
        o_busy          = 1'b0;
        o_done          = 1'b0;
        mem_bus.read_en = 1'b0;
`ifdef DW_KERNEL_AUTOSTART_EN
        o_conv_clear    = 1'b0;
        o_conv_start    = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_load_start) begin
                    w_state_d = StReq;
                end
            end
            StReq: begin
                o_busy          = 1'b1;
                mem_bus.read_en = 1'b1;
                w_state_d       = StWait;
            end
            StWait: begin
                o_busy = 1'b1;
                if (mem_bus.read_valid) begin
                    if (w_last_tap) begin
`ifdef DW_KERNEL_AUTOSTART_EN
                        w_state_d = StClr;
`else
                        w_state_d = StDone;
`endif
                    end else begin
                        w_state_d = StReq;
                    end
                end else if (w_timeout) begin
                    w_state_d = StErr;
                end
            end
`ifdef DW_KERNEL_AUTOSTART_EN
            StClr: begin
                o_busy       = 1'b1;
                o_conv_clear = 1'b1;
                w_state_d    = StStrt;
            end
            StStrt: begin
                o_busy       = 1'b1;
                o_conv_start = 1'b1;
                w_state_d    = StDone;
            end
`endif
            StDone: begin
                o_busy    = 1'b1;
                o_done    = 1'b1;
                w_state_d = StIdle;
            end
            StErr: begin
                // error is already visible from r_error; busy drops here
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Datapath: base latch, tap index, timeout counter, tap capture and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_base         <= '0;
            r_index        <= '0;
            r_timer        <= '0;
            r_kernel_valid <= 1'b0;
            r_error        <= 1'b0;
            for (int i = 0; i < int'(KERNEL_TAPS); i++) begin
                r_kernel[i] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_load_start) begin
                        r_base         <= i_base_addr;
                        r_index        <= '0;
                        r_kernel_valid <= 1'b0;
                        r_error        <= 1'b0;
                    end
                end
                StReq: begin
                    r_timer <= '0;
                end
                StWait: begin
                    if (mem_bus.read_valid) begin
                        r_kernel[r_index] <= mem_bus.read_data;
                        if (w_last_tap) begin
                            // Kernel is complete as of this capture.
                            r_kernel_valid <= 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        if (w_timeout) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
